// File: rtl/ber_pkg.sv
// Shared definitions for the BER fault-injection path and its mask generator.
package ber_pkg;

    localparam int unsigned BerWidth = 64;

    typedef enum logic [1:0] {
        FLIP   = 2'd0,
        STUCK0 = 2'd1,
        STUCK1 = 2'd2,
        RSVD   = 2'd3
    } fault_mode_e;

endpackage

// File: rtl/ber_popcount.sv
// Combinational population count built as a pairwise adder tree.
module ber_popcount
    import ber_pkg::*;
#(
    parameter int unsigned DataWidth = BerWidth,
    parameter int unsigned OutWidth  = $clog2(DataWidth) + 1
) (
    input  logic [DataWidth-1:0] i_data,
    output logic [OutWidth-1:0]  o_count
);

    localparam int unsigned IdxWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;

    logic [OutWidth-1:0] w_node [DataWidth];

    // Each level folds node i+span into node i; node 0 ends up holding the total.
    always_comb begin
        for (int i = 0; i < int'(DataWidth); i++) begin
            w_node[IdxWidth'(i)] = OutWidth'(i_data[IdxWidth'(i)]);
        end
        for (int span = 1; span < int'(DataWidth); span = span * 2) begin
            for (int i = 0; i + span < int'(DataWidth); i = i + 2 * span) begin
                w_node[IdxWidth'(i)] = w_node[IdxWidth'(i)] + w_node[IdxWidth'(i + span)];
            end
        end
        o_count = w_node[0];
    end

endmodule

// File: rtl/ber_fault_inject.sv
// Applies a generator mask to each accepted read beat (flip / stuck-at),
// registers the result behind valid/ready, and keeps saturating statistics.
module ber_fault_inject
    import ber_pkg::*;
#(
    parameter int unsigned DataWidth = BerWidth,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_en_i,
    input  logic [1:0]           cfg_mode_i,
    input  logic                 cnt_clr_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 mask_en_o,
    input  logic [DataWidth-1:0] mask_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_faulty_o,
    output logic [CntWidth-1:0]  flip_cnt_o,
    output logic [CntWidth-1:0]  beat_cnt_o
);

    localparam int unsigned PopWidth = $clog2(DataWidth) + 1;
    localparam int unsigned SumWidth = CntWidth + 1;

    logic                 r_out_valid;
    logic [DataWidth-1:0] r_out_data;
    logic                 r_out_faulty;
    logic [CntWidth-1:0]  r_flip_cnt;
    logic [CntWidth-1:0]  r_beat_cnt;

    logic                 w_accept;
    logic                 w_inject;
    fault_mode_e          w_mode;
    logic [DataWidth-1:0] w_corrupt;
    logic [DataWidth-1:0] w_diff;
    logic [PopWidth-1:0]  w_pop;
    logic [SumWidth-1:0]  w_flip_sum;
    logic [SumWidth-1:0]  w_beat_sum;

    assign in_ready_o = !r_out_valid | out_ready_i;
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_inject   = w_accept & cfg_en_i;
    // Gated by reset so the generator never advances while it is held in reset.
    assign mask_en_o  = w_inject & rst_ni;
    assign w_mode     = fault_mode_e'(cfg_mode_i);

    always_comb begin
        w_corrupt = in_data_i;
        if (cfg_en_i) begin
            case (w_mode)
                STUCK0:  w_corrupt = in_data_i & ~mask_i;
                STUCK1:  w_corrupt = in_data_i | mask_i;
                default: w_corrupt = in_data_i ^ mask_i;
            endcase
        end
    end

    assign w_diff = w_corrupt ^ in_data_i;

    ber_popcount #(
        .DataWidth (DataWidth),
        .OutWidth  (PopWidth)
    ) u_popcount (
        .i_data  (w_diff),
        .o_count (w_pop)
    );

    // One extra carry bit detects overflow so the counters saturate.
    assign w_flip_sum = {1'b0, r_flip_cnt} + SumWidth'(w_pop);
    assign w_beat_sum = {1'b0, r_beat_cnt} + SumWidth'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_faulty <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_corrupt;
            r_out_faulty <= |w_diff;
        end else if (out_ready_i) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flip_cnt <= '0;
            r_beat_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_flip_cnt <= '0;
            r_beat_cnt <= '0;
        end else if (w_inject) begin
            r_flip_cnt <= w_flip_sum[CntWidth] ? '1 : w_flip_sum[CntWidth-1:0];
            r_beat_cnt <= w_beat_sum[CntWidth] ? '1 : w_beat_sum[CntWidth-1:0];
        end
    end

    assign out_valid_o  = r_out_valid;
    assign out_data_o   = r_out_data;
    assign out_faulty_o = r_out_faulty;
    assign flip_cnt_o   = r_flip_cnt;
    assign beat_cnt_o   = r_beat_cnt;

endmodule
